dispatcher: RTL and testbench

DISPATCHER -- requirements
Module: dispatcher

---
 rtl/dispatcher_pkg.sv | 50 +++++
 rtl/dispatcher.sv | 134 +++++++++++++
 tb/tb_dispatcher.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatcher_pkg.sv
// Shared defines for the dispatch stage: operation enum encoding, ROB tag width,
// register/instruction types and the dispatcher FSM state type.
package dispatcher_pkg;

    localparam int OPENUM_W  = 6;
    localparam int ROB_POS_W = 4;

    typedef logic [4:0]  reg_pos_t;
    typedef logic [31:0] ins_t;

    // Loads and stores are contiguous (LB..SW) so LSB routing is a range check.
    localparam logic [OPENUM_W-1:0] OPENUM_NOP   = 6'd0;
    localparam logic [OPENUM_W-1:0] OPENUM_LUI   = 6'd1;
    localparam logic [OPENUM_W-1:0] OPENUM_AUIPC = 6'd2;
    localparam logic [OPENUM_W-1:0] OPENUM_JAL   = 6'd3;
    localparam logic [OPENUM_W-1:0] OPENUM_JALR  = 6'd4;
    localparam logic [OPENUM_W-1:0] OPENUM_BEQ   = 6'd5;
    localparam logic [OPENUM_W-1:0] OPENUM_BNE   = 6'd6;
    localparam logic [OPENUM_W-1:0] OPENUM_BLT   = 6'd7;
    localparam logic [OPENUM_W-1:0] OPENUM_BGE   = 6'd8;
    localparam logic [OPENUM_W-1:0] OPENUM_BLTU  = 6'd9;
    localparam logic [OPENUM_W-1:0] OPENUM_BGEU  = 6'd10;
    localparam logic [OPENUM_W-1:0] OPENUM_LB    = 6'd11;
    localparam logic [OPENUM_W-1:0] OPENUM_LH    = 6'd12;
    localparam logic [OPENUM_W-1:0] OPENUM_LW    = 6'd13;
    localparam logic [OPENUM_W-1:0] OPENUM_LBU   = 6'd14;
    localparam logic [OPENUM_W-1:0] OPENUM_LHU   = 6'd15;
    localparam logic [OPENUM_W-1:0] OPENUM_SB    = 6'd16;
    localparam logic [OPENUM_W-1:0] OPENUM_SH    = 6'd17;
    localparam logic [OPENUM_W-1:0] OPENUM_SW    = 6'd18;
    // ALU-immediate ops follow funct3 order: ADDI, SLLI, SLTI, SLTIU, XORI, SRLI, ORI, ANDI.
    localparam logic [OPENUM_W-1:0] OPENUM_ADDI  = 6'd19;
    localparam logic [OPENUM_W-1:0] OPENUM_ANDI  = 6'd26;
    // Register-register ops follow funct3 order: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
    localparam logic [OPENUM_W-1:0] OPENUM_ADD   = 6'd27;
    localparam logic [OPENUM_W-1:0] OPENUM_AND   = 6'd34;
    localparam logic [OPENUM_W-1:0] OPENUM_SUB   = 6'd35;
    localparam logic [OPENUM_W-1:0] OPENUM_SRA   = 6'd36;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        ISSUE
    } disp_state_t;

    function automatic logic is_lsb_op(input logic [OPENUM_W-1:0] op);
        return (op >= OPENUM_LB) && (op <= OPENUM_SW);
    endfunction

endpackage

// File: rtl/dispatcher.sv
// Dispatch stage: takes one fetched instruction, hands it to the external decoder,
// then issues the decoded fields to the RS or LSB once the ROB and target have room.
module dispatcher
    import dispatcher_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [31:0]          if_inst,
    input  logic [31:0]          if_pc,
    output logic                 if_ready,
    output logic [31:0]          dcd_inst,
    input  logic [OPENUM_W-1:0]  dcd_op_enum,
    input  logic [4:0]           dcd_rd,
    input  logic [4:0]           dcd_rs1,
    input  logic [4:0]           dcd_rs2,
    input  logic [31:0]          dcd_imm,
    input  logic                 rob_full,
    input  logic                 rs_full,
    input  logic                 lsb_full,
    input  logic [ROB_POS_W-1:0] rob_free_tag,
    input  logic                 flush,
    output logic                 issue_valid,
    output logic                 issue_to_lsb,
    output logic [OPENUM_W-1:0]  issue_op,
    output logic [4:0]           issue_rd,
    output logic [4:0]           issue_rs1,
    output logic [4:0]           issue_rs2,
    output logic [31:0]          issue_imm,
    output logic [31:0]          issue_pc,
    output logic [ROB_POS_W-1:0] issue_tag,
    output logic [31:0]          issue_cnt
);

    disp_state_t          state;
    disp_state_t          state_next;

    ins_t                 inst_q;
    logic [31:0]          pc_q;
    logic [OPENUM_W-1:0]  op_q;
    reg_pos_t             rd_q;
    reg_pos_t             rs1_q;
    reg_pos_t             rs2_q;
    logic [31:0]          imm_q;
    logic                 to_lsb_q;

    logic                 can_issue;
    logic                 accept;
    logic                 latch_dcd;
    logic                 fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over everything, including an issue that would otherwise fire this edge.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (if_valid) state_next = DECODE;
                DECODE:  state_next = (dcd_op_enum == OPENUM_NOP) ? IDLE : ISSUE;
                ISSUE:   if (can_issue) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        if_ready  = (state == IDLE);
        can_issue = !rob_full && !(to_lsb_q ? lsb_full : rs_full);
        accept    = (state == IDLE) && if_valid && !flush;
        latch_dcd = (state == DECODE) && !flush && (dcd_op_enum != OPENUM_NOP);
        fire      = (state == ISSUE) && !flush && can_issue;
    end

    // Issue fields are only loaded on the firing edge, so they stay stable for the pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q       <= '0;
            pc_q         <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            to_lsb_q     <= 1'b0;
            issue_valid  <= 1'b0;
            issue_to_lsb <= 1'b0;
            issue_op     <= '0;
            issue_rd     <= '0;
            issue_rs1    <= '0;
            issue_rs2    <= '0;
            issue_imm    <= '0;
            issue_pc     <= '0;
            issue_tag    <= '0;
            issue_cnt    <= '0;
        end else begin
            issue_valid <= fire;
            if (accept) begin
                inst_q <= if_inst;
                pc_q   <= if_pc;
            end
            if (latch_dcd) begin
                op_q     <= dcd_op_enum;
                rd_q     <= dcd_rd;
                rs1_q    <= dcd_rs1;
                rs2_q    <= dcd_rs2;
                imm_q    <= dcd_imm;
                to_lsb_q <= is_lsb_op(dcd_op_enum);
            end
            if (fire) begin
                issue_to_lsb <= to_lsb_q;
                issue_op     <= op_q;
                issue_rd     <= rd_q;
                issue_rs1    <= rs1_q;
                issue_rs2    <= rs2_q;
                issue_imm    <= imm_q;
                issue_pc     <= pc_q;
                issue_tag    <= rob_free_tag;
                issue_cnt    <= issue_cnt + 32'd1;
            end
        end
    end

    assign dcd_inst = inst_q;

endmodule

// File: tb/tb_dispatcher.sv
// Bench for the dispatcher: a behavioural RV32I decoder stands in for the external
// Decoder, directed scenarios cover the named instructions, and a random run uses a pending-slot model.
module tb_dispatcher;
    import dispatcher_pkg::*;

    typedef struct packed {
        logic [OPENUM_W-1:0] op;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         imm;
    } dec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 if_valid = 1'b0;
    logic [31:0]          if_inst = '0;
    logic [31:0]          if_pc = '0;
    logic                 if_ready;
    logic [31:0]          dcd_inst;
    logic                 rob_full = 1'b0;
    logic                 rs_full = 1'b0;
    logic                 lsb_full = 1'b0;
    logic [ROB_POS_W-1:0] rob_free_tag = '0;
    logic                 flush = 1'b0;
    logic                 issue_valid;
    logic                 issue_to_lsb;
    logic [OPENUM_W-1:0]  issue_op;
    logic [4:0]           issue_rd;
    logic [4:0]           issue_rs1;
    logic [4:0]           issue_rs2;
    logic [31:0]          issue_imm;
    logic [31:0]          issue_pc;
    logic [ROB_POS_W-1:0] issue_tag;
    logic [31:0]          issue_cnt;
    dec_t                 dd;

    int n_checks = 0;
    int n_fail   = 0;

    dispatcher dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
        .dcd_inst(dcd_inst), .dcd_op_enum(dd.op), .dcd_rd(dd.rd), .dcd_rs1(dd.rs1),
        .dcd_rs2(dd.rs2), .dcd_imm(dd.imm),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_free_tag(rob_free_tag), .flush(flush),
        .issue_valid(issue_valid), .issue_to_lsb(issue_to_lsb), .issue_op(issue_op),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_tag(issue_tag),
        .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural RV32I subset decoder; unsupported encodings decode to NOP.
    function automatic dec_t decode(input logic [31:0] i);
        dec_t       d;
        logic [2:0] f3;
        d  = '0;
        f3 = i[14:12];
        case (i[6:0])
            7'h13: begin
                d.op  = OPENUM_ADDI + {3'b000, f3};
                d.rd  = i[11:7];
                d.rs1 = i[19:15];
                d.imm = {{20{i[31]}}, i[31:20]};
            end
            7'h33: begin
                d.op  = OPENUM_ADD + {3'b000, f3};
                d.rd  = i[11:7];
                d.rs1 = i[19:15];
                d.rs2 = i[24:20];
            end
            7'h03: begin
                case (f3)
                    3'd0: d.op = OPENUM_LB;
                    3'd1: d.op = OPENUM_LH;
                    3'd2: d.op = OPENUM_LW;
                    3'd4: d.op = OPENUM_LBU;
                    3'd5: d.op = OPENUM_LHU;
                    default: d.op = OPENUM_NOP;
                endcase
                d.rd  = i[11:7];
                d.rs1 = i[19:15];
                d.imm = {{20{i[31]}}, i[31:20]};
            end
            7'h23: begin
                case (f3)
                    3'd0: d.op = OPENUM_SB;
                    3'd1: d.op = OPENUM_SH;
                    3'd2: d.op = OPENUM_SW;
                    default: d.op = OPENUM_NOP;
                endcase
                d.rs1 = i[19:15];
                d.rs2 = i[24:20];
                d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            7'h63: begin
                case (f3)
                    3'd0: d.op = OPENUM_BEQ;
                    3'd1: d.op = OPENUM_BNE;
                    3'd4: d.op = OPENUM_BLT;
                    3'd5: d.op = OPENUM_BGE;
                    3'd6: d.op = OPENUM_BLTU;
                    3'd7: d.op = OPENUM_BGEU;
                    default: d.op = OPENUM_NOP;
                endcase
                d.rs1 = i[19:15];
                d.rs2 = i[24:20];
                d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    assign dd = decode(dcd_inst);

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  opc [6];
        opc     = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h33, 7'h00};
        w       = $urandom;
        w[6:0]  = opc[$urandom_range(0, 5)];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue(input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (cycles < budget && !seen) begin
            step();
            cycles++;
            if (issue_valid) seen = 1'b1;
        end
    endtask

    task automatic accept_inst(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
        step();
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({if_ready, issue_valid, issue_cnt, dcd_inst} !== {1'b1, 1'b0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got ready=%0b valid=%0b cnt=%0d inst=%h, expected 1 0 0 0",
                     if_ready, issue_valid, issue_cnt, dcd_inst);
        end
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (if_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_release_ready: got %0b expected 1", if_ready);
        end
    endtask

    task automatic test_addi();
        int n;
        bit seen;
        rob_free_tag = 4'd5;
        accept_inst(32'hfd010113, 32'h0000_0100);
        n_checks++;
        if (if_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL addi_busy: if_ready got %0b expected 0", if_ready);
        end
        wait_issue(10, n, seen);
        n_checks++;
        if (!seen || n != 2) begin
            n_fail++;
            $display("[TB] FAIL addi_latency: pulse seen=%0b after %0d cycles, expected 2", seen, n);
        end
        n_checks++;
        if ({issue_to_lsb, issue_op, issue_rd, issue_rs1, issue_imm, issue_pc, issue_tag, issue_cnt} !==
            {1'b0, OPENUM_ADDI, 5'd2, 5'd2, 32'hffff_ffd0, 32'h0000_0100, 4'd5, 32'd1}) begin
            n_fail++;
            $display("[TB] FAIL addi_fields: got lsb=%0b op=%0d rd=%0d rs1=%0d imm=%h pc=%h tag=%0d cnt=%0d, expected 0 %0d 2 2 ffffffd0 00000100 5 1",
                     issue_to_lsb, issue_op, issue_rd, issue_rs1, issue_imm, issue_pc, issue_tag, issue_cnt, OPENUM_ADDI);
        end
        step();
        n_checks++;
        if (issue_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL addi_single_pulse: issue_valid got %0b expected 0", issue_valid);
        end
    endtask

    task automatic test_sw();
        int n;
        bit seen;
        rob_free_tag = 4'd9;
        accept_inst(32'h02912223, 32'h0000_0104);
        wait_issue(10, n, seen);
        n_checks++;
        if (!seen || n != 2) begin
            n_fail++;
            $display("[TB] FAIL sw_latency: pulse seen=%0b after %0d cycles, expected 2", seen, n);
        end
        n_checks++;
        if ({issue_to_lsb, issue_op, issue_rs1, issue_rs2, issue_imm, issue_tag, issue_cnt} !==
            {1'b1, OPENUM_SW, 5'd2, 5'd9, 32'd36, 4'd9, 32'd2}) begin
            n_fail++;
            $display("[TB] FAIL sw_fields: got lsb=%0b op=%0d rs1=%0d rs2=%0d imm=%0d tag=%0d cnt=%0d, expected 1 %0d 2 9 36 9 2",
                     issue_to_lsb, issue_op, issue_rs1, issue_rs2, issue_imm, issue_tag, issue_cnt, OPENUM_SW);
        end
        step();
    endtask

    task automatic test_rob_stall();
        int pulses;
        pulses = 0;
        rob_full = 1'b1;
        accept_inst(32'hfe891ae3, 32'h0000_0108);
        for (int i = 0; i < 4; i++) begin
            step();
            if (issue_valid) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("[TB] FAIL bne_stall_no_pulse: got %0d pulses while rob_full, expected 0", pulses);
        end
        rob_full = 1'b0;
        step();
        n_checks++;
        if ({issue_valid, issue_to_lsb, issue_op, issue_rs1, issue_rs2, issue_imm} !==
            {1'b1, 1'b0, OPENUM_BNE, 5'd18, 5'd8, 32'hffff_fff4}) begin
            n_fail++;
            $display("[TB] FAIL bne_release: got valid=%0b lsb=%0b op=%0d rs1=%0d rs2=%0d imm=%h, expected 1 0 %0d 18 8 fffffff4",
                     issue_valid, issue_to_lsb, issue_op, issue_rs1, issue_rs2, issue_imm, OPENUM_BNE);
        end
        step();
        n_checks++;
        if ({issue_valid, issue_cnt} !== {1'b0, 32'd3}) begin
            n_fail++;
            $display("[TB] FAIL bne_once: got valid=%0b cnt=%0d, expected 0 3", issue_valid, issue_cnt);
        end
    endtask

    task automatic test_flush_stall();
        int pulses;
        pulses = 0;
        lsb_full = 1'b1;
        accept_inst(32'h02412483, 32'h0000_010c);
        for (int i = 0; i < 5; i++) begin
            step();
            if (issue_valid) pulses++;
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if ({if_ready, issue_valid} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL lw_flush_idle: got ready=%0b valid=%0b, expected 1 0", if_ready, issue_valid);
        end
        lsb_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (issue_valid) pulses++;
        end
        n_checks++;
        if (pulses != 0 || issue_cnt !== 32'd3) begin
            n_fail++;
            $display("[TB] FAIL lw_flush_no_issue: got %0d pulses cnt=%0d, expected 0 pulses cnt=3", pulses, issue_cnt);
        end
    endtask

    task automatic test_flush_idle();
        int pulses;
        pulses = 0;
        if_valid = 1'b1;
        flush    = 1'b1;
        if_inst  = 32'hfd010113;
        step();
        if_valid = 1'b0;
        flush    = 1'b0;
        n_checks++;
        if (if_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL flush_idle_not_accepted: if_ready got %0b expected 1", if_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (issue_valid) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("[TB] FAIL flush_idle_no_issue: got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_nop_reset();
        int pulses;
        pulses = 0;
        accept_inst(32'h0000_0000, 32'h0000_0110);
        step();
        n_checks++;
        if (if_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL nop_back_to_idle: if_ready got %0b expected 1", if_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (issue_valid) pulses++;
        end
        n_checks++;
        if (pulses != 0 || issue_cnt !== 32'd3) begin
            n_fail++;
            $display("[TB] FAIL nop_no_issue: got %0d pulses cnt=%0d, expected 0 pulses cnt=3", pulses, issue_cnt);
        end
        rob_full = 1'b1;
        accept_inst(32'hfd010113, 32'h0000_0114);
        step();
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({if_ready, issue_valid, issue_cnt, dcd_inst, issue_rd, issue_imm, issue_pc} !==
            {1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got ready=%0b valid=%0b cnt=%0d inst=%h rd=%0d imm=%h pc=%h, expected all zero except ready=1",
                     if_ready, issue_valid, issue_cnt, dcd_inst, issue_rd, issue_imm, issue_pc);
        end
        rob_full = 1'b0;
        #1;
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (issue_valid) pulses++;
        end
        n_checks++;
        if (pulses != 0 || issue_cnt !== 32'd0 || if_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_discard: got %0d pulses cnt=%0d ready=%0b, expected 0 0 1", pulses, issue_cnt, if_ready);
        end
    endtask

    // Model: at most one instruction in flight; it decodes one edge after acceptance and
    // may issue on any later edge where the ROB and its target have room and no flush is seen.
    task automatic test_random();
        bit          pending;
        int          age;
        logic [31:0] p_inst;
        logic [31:0] p_pc;
        int          exp_cnt;
        bit          exp_issue;
        bit          lsb;
        dec_t        d;
        dec_t        e;
        bit          e_lsb;
        logic [31:0] e_pc;
        logic [3:0]  e_tag;
        pending = 1'b0;
        age     = 0;
        p_inst  = '0;
        p_pc    = '0;
        exp_cnt = 0;
        e       = '0;
        e_lsb   = 1'b0;
        e_pc    = '0;
        e_tag   = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if_valid     = ($urandom_range(0, 9) < 7);
            if_inst      = rand_inst();
            if_pc        = $urandom;
            rob_full     = ($urandom_range(0, 3) == 0);
            rs_full      = ($urandom_range(0, 3) == 0);
            lsb_full     = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 24) == 0);
            rob_free_tag = 4'($urandom);
            exp_issue    = 1'b0;
            if (flush) begin
                pending = 1'b0;
            end else if (pending) begin
                d = decode(p_inst);
                if (age == 0) begin
                    if (d.op == OPENUM_NOP) pending = 1'b0;
                    else age = 1;
                end else begin
                    lsb = (d.op >= OPENUM_LB) && (d.op <= OPENUM_SW);
                    if (!rob_full && !(lsb ? lsb_full : rs_full)) begin
                        exp_issue = 1'b1;
                        pending   = 1'b0;
                        exp_cnt++;
                        e     = d;
                        e_lsb = lsb;
                        e_pc  = p_pc;
                        e_tag = rob_free_tag;
                    end
                end
            end else if (if_valid) begin
                pending = 1'b1;
                age     = 0;
                p_inst  = if_inst;
                p_pc    = if_pc;
            end
            step();
            n_checks++;
            if (issue_valid !== exp_issue) begin
                n_fail++;
                $display("[TB] FAIL rand_issue_valid cycle %0d: got %0b expected %0b", cyc, issue_valid, exp_issue);
            end
            if (exp_issue) begin
                n_checks++;
                if ({issue_op, issue_rd, issue_rs1, issue_rs2, issue_imm, issue_to_lsb, issue_pc, issue_tag} !==
                    {e, e_lsb, e_pc, e_tag}) begin
                    n_fail++;
                    $display("[TB] FAIL rand_issue_fields cycle %0d: got op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h lsb=%0b pc=%h tag=%0d, expected op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h lsb=%0b pc=%h tag=%0d",
                             cyc, issue_op, issue_rd, issue_rs1, issue_rs2, issue_imm, issue_to_lsb, issue_pc, issue_tag,
                             e.op, e.rd, e.rs1, e.rs2, e.imm, e_lsb, e_pc, e_tag);
                end
            end
            n_checks++;
            if (issue_cnt !== 32'(exp_cnt)) begin
                n_fail++;
                $display("[TB] FAIL rand_issue_cnt cycle %0d: got %0d expected %0d", cyc, issue_cnt, exp_cnt);
            end
            n_checks++;
            if (if_ready !== !pending) begin
                n_fail++;
                $display("[TB] FAIL rand_if_ready cycle %0d: got %0b expected %0b", cyc, if_ready, !pending);
            end
        end
        if_valid = 1'b0;
        flush    = 1'b0;
        rob_full = 1'b0;
        rs_full  = 1'b0;
        lsb_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sw();
        test_rob_stall();
        test_flush_stall();
        test_flush_idle();
        test_nop_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
